// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// ----------------------------------------------------------------------------
// Parametrised single-clock synchronous FIFO with registered read data.
// All DEPTH entries are usable: the pointers carry one extra wrap bit, which
// tells "full" apart from "empty" when the index bits are equal.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   wr_e          write request
//   wr_data       write data word (DATA_W bits)
//   rd_e          read request
//   rd_data       registered read data, updated only when a read is accepted
//   rd_valid      rd_data holds a newly popped word this cycle
//   full          occupancy == DEPTH
//   empty         occupancy == 0
//   almost_full   occupancy >= AF_LEVEL
//   almost_empty  occupancy <= AE_LEVEL
//   count         current occupancy, 0..DEPTH (AW+1 bits)
//   overflow      sticky, set when a write request is rejected
//   underflow     sticky, set when a read request is rejected
// ----------------------------------------------------------------------------
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_e,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_e,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] AF_THRESH = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_THRESH = (AW+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        rd_acc;
  logic        wr_acc;

  // Status flags all come straight from the pointers, so they describe the
  // state left behind by the most recent edge.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                        (wr_ptr[AW] != rd_ptr[AW]);
  assign almost_full  = (count >= AF_THRESH);
  assign almost_empty = (count <= AE_THRESH);

  // A read frees a slot in the same edge, so a write against a full FIFO
  // still goes in when it is paired with an accepted read. There is no
  // fall-through: a read against an empty FIFO is rejected even if a write
  // arrives in the same cycle.
  assign rd_acc = rd_e & ~empty;
  assign wr_acc = wr_e & (~full | rd_acc);

  // Storage has no reset so it can map onto distributed RAM; writes are
  // suppressed during reset so in-flight data is simply dropped.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_data  <= mem[rd_ptr[AW-1:0]];
        rd_valid <= 1'b1;
        rd_ptr   <= rd_ptr + PTR_ONE;
      end else begin
        rd_valid <= 1'b0;
      end
      if (wr_e && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_e && !rd_acc) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param
// ----------------------------------------------------------------------------
// Self-checking bench for fifo_sync_param (DATA_W=8, DEPTH=8, AF_LEVEL=6,
// AE_LEVEL=2). A fixed vector table covers reset, fill, overflow, drain and
// underflow; hand-written sequences cover the multi-cycle corner cases; a
// randomized phase is compared against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_fifo_sync_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF_LVL = 6;
  localparam int AE_LVL = 2;

  logic              clk;
  logic              rst;
  logic              wr_e;
  logic [DATA_W-1:0] wr_data;
  logic              rd_e;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [3:0]        count;
  logic              overflow;
  logic              underflow;

  fifo_sync_param #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF_LVL),
    .AE_LEVEL(AE_LVL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_e        (wr_e),
    .wr_data     (wr_data),
    .rd_e        (rd_e),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference model: the FIFO contents as a plain queue plus the registered
  // read-side outputs and the sticky error flags.
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] m_rd_data;
  logic              m_rd_valid;
  logic              m_ovf;
  logic              m_unf;

  typedef struct {
    logic        rst;
    logic        we;
    logic [7:0]  wd;
    logic        re;
    int          cnt;
    logic        vld;
    logic [7:0]  rdd;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic we, input logic [7:0] wd,
                              input logic re, input int cnt, input logic vld,
                              input logic [7:0] rdd, input logic fu, input logic em,
                              input logic af, input logic ae, input logic ovf,
                              input logic unf);
    vec_t v;
    v.rst = r;  v.we = we;  v.wd = wd;  v.re = re;
    v.cnt = cnt; v.vld = vld; v.rdd = rdd; v.full = fu; v.empty = em;
    v.af = af;  v.ae = ae;  v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model
  // with the same inputs.
  task automatic applyStimulus(input logic r, input logic we, input logic [7:0] wd,
                               input logic re);
    logic racc;
    logic wacc;
    rst     = r;
    wr_e    = we;
    wr_data = wd;
    rd_e    = re;
    @(posedge clk);
    #1;
    if (r) begin
      model_q.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
    end else begin
      racc = re && (model_q.size() > 0);
      wacc = we && ((model_q.size() < DEPTH) || racc);
      if (racc) begin
        m_rd_data  = model_q.pop_front();
        m_rd_valid = 1'b1;
      end else begin
        m_rd_valid = 1'b0;
      end
      if (wacc) model_q.push_back(wd);
      if (we && !wacc) m_ovf = 1'b1;
      if (re && !racc) m_unf = 1'b1;
    end
  endtask

  task automatic checkOutput(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".count"},        int'(count),        n);
    chk({tag, ".empty"},        int'(empty),        int'(n == 0));
    chk({tag, ".full"},         int'(full),         int'(n == DEPTH));
    chk({tag, ".almost_full"},  int'(almost_full),  int'(n >= AF_LVL));
    chk({tag, ".almost_empty"}, int'(almost_empty), int'(n <= AE_LVL));
    chk({tag, ".rd_valid"},     int'(rd_valid),     int'(m_rd_valid));
    chk({tag, ".rd_data"},      int'(rd_data),      int'(m_rd_data));
    chk({tag, ".overflow"},     int'(overflow),     int'(m_ovf));
    chk({tag, ".underflow"},    int'(underflow),    int'(m_unf));
  endtask

  task automatic checkRow(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    chk({tag, ".count"},        int'(count),        v.cnt);
    chk({tag, ".rd_valid"},     int'(rd_valid),     int'(v.vld));
    chk({tag, ".rd_data"},      int'(rd_data),      int'(v.rdd));
    chk({tag, ".full"},         int'(full),         int'(v.full));
    chk({tag, ".empty"},        int'(empty),        int'(v.empty));
    chk({tag, ".almost_full"},  int'(almost_full),  int'(v.af));
    chk({tag, ".almost_empty"}, int'(almost_empty), int'(v.ae));
    chk({tag, ".overflow"},     int'(overflow),     int'(v.ovf));
    chk({tag, ".underflow"},    int'(underflow),    int'(v.unf));
  endtask

  initial begin
    rst = 1'b1; wr_e = 1'b0; wr_data = '0; rd_e = 1'b0;
    model_q.delete();
    m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    //            rst we wd     re | cnt vld rdd   full em af ae ovf unf
    vecs.push_back(mk(1, 0, 8'h00, 0,  0, 0, 8'h00, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0,  0, 0, 8'h00, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h01, 0,  1, 0, 8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h02, 0,  2, 0, 8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h03, 0,  3, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h04, 0,  4, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h05, 0,  5, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h06, 0,  6, 0, 8'h00, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h07, 0,  7, 0, 8'h00, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h08, 0,  8, 0, 8'h00, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'hFF, 0,  8, 0, 8'h00, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  7, 1, 8'h01, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  6, 1, 8'h02, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  5, 1, 8'h03, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  4, 1, 8'h04, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  3, 1, 8'h05, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  2, 1, 8'h06, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h07, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  0, 1, 8'h08, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  0, 0, 8'h08, 0, 1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0,  0, 0, 8'h08, 0, 1, 0, 1, 1, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0,  0, 0, 8'h00, 0, 1, 0, 1, 0, 0));

    $display("[TB] vector table: %0d rows", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].re);
      checkRow(vecs[i], i);
    end

    // Full FIFO with a simultaneous read and write: both accepted.
    $display("[TB] sequence: read+write while full");
    for (int i = 1; i <= DEPTH; i++) applyStimulus(0, 1, 8'(i), 0);
    applyStimulus(0, 1, 8'hAA, 1);
    chk("simul_full.rd_data", int'(rd_data), 8'h01);
    chk("simul_full.count", int'(count), DEPTH);
    chk("simul_full.overflow", int'(overflow), 0);
    checkOutput("simul_full");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 8'h00, 1);
      checkOutput($sformatf("simul_drain%0d", i));
    end
    chk("simul_drain.last", int'(rd_data), 8'hAA);

    // Empty FIFO with a simultaneous read and write: no fall-through.
    $display("[TB] sequence: read+write while empty");
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h5C, 1);
    chk("empty_rw.underflow", int'(underflow), 1);
    chk("empty_rw.count", int'(count), 1);
    chk("empty_rw.rd_valid", int'(rd_valid), 0);
    applyStimulus(0, 0, 8'h00, 1);
    chk("empty_rw.read_back", int'(rd_data), 8'h5C);
    checkOutput("empty_rw");

    // Reset with requests active, then wrap the pointers repeatedly.
    $display("[TB] sequence: reset override and pointer wrap");
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'(8'h30 + i), 0);
    applyStimulus(1, 1, 8'hEE, 1);
    chk("rst_override.count", int'(count), 0);
    chk("rst_override.empty", int'(empty), 1);
    chk("rst_override.rd_valid", int'(rd_valid), 0);
    chk("rst_override.overflow", int'(overflow), 0);
    chk("rst_override.underflow", int'(underflow), 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 8'(i), 0);
      applyStimulus(0, 0, 8'h00, 1);
      chk($sformatf("wrap%0d.rd_data", i), int'(rd_data), i);
      checkOutput($sformatf("wrap%0d", i));
    end

    // Randomized traffic with biased phases so full and empty both occur.
    $display("[TB] randomized phase");
    for (int i = 0; i < 800; i++) begin
      int bias;
      logic r;
      logic we;
      logic re;
      bias = ((i / 50) % 2 == 0) ? 75 : 25;
      r  = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 99) < bias);
      re = ($urandom_range(0, 99) < (100 - bias));
      applyStimulus(r, we, 8'($urandom_range(0, 255)), re);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
